toggle_bank_arbiter: RTL and testbench

TOGGLE_BANK_ARBITER -- requirements
Module: toggle_bank_arbiter

---
 rtl/toggle_bank_arbiter_if.sv | 35 +++
 rtl/toggle_bank_arbiter.sv | 128 ++++++++++++
 tb/tb_toggle_bank_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/toggle_bank_arbiter_if.sv
// rtl/toggle_bank_arbiter_if.sv - request/grant/toggle bus shared by requesters and the arbiter
//
// Purpose: groups the request handshake, the per-requester toggle masks and the
// toggle bank readback into one bundle.
// Signals:
//   clr   synchronous clear of the toggle bank (requester side drives)
//   req   per-requester request, held until the matching ack
//   mask  per-requester toggle masks, slice i = [i*WIDTH +: WIDTH]
//   gnt   one-hot grant (arbiter drives)
//   ack   one-cycle completion pulse (arbiter drives)
//   q     toggle bank state (arbiter drives)
//   busy  arbiter is mid-transaction (arbiter drives)
// Modports: master = requester side, slave = arbiter side.
interface toggle_bank_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) ();
  logic                     clr;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   mask;
  logic [N_REQ-1:0]         gnt;
  logic [N_REQ-1:0]         ack;
  logic [WIDTH-1:0]         q;
  logic                     busy;

  modport master (
    output clr, req, mask,
    input  gnt, ack, q, busy
  );

  modport slave (
    input  clr, req, mask,
    output gnt, ack, q, busy
  );
endinterface

// File: rtl/toggle_bank_arbiter.sv
// rtl/toggle_bank_arbiter.sv - round-robin arbiter granting access to a shared toggle flip-flop bank
//
// Purpose: N_REQ requesters each present a toggle mask; one at a time is granted,
// its mask captured, and the shared bank q is XORed with it.
// Ports:
//   clk_i-style scalar clk  clock, rising edge
//   rst                     asynchronous active-high reset
//   bus (slave modport)     clr/req/mask in, gnt/ack/q/busy out
module toggle_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  toggle_bank_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [WIDTH-1:0]     t_q, t_d;
  logic [WIDTH-1:0]     q_q, q_d;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     cand;
  logic [WIDTH-1:0]     mask_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_mask
    assign mask_arr[g] = bus.mask[g*WIDTH +: WIDTH];
  end

  // Round-robin search starting at last_served+1. Walking the offsets from
  // farthest to nearest lets the nearest requesting index win by overwrite.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IDX_W'((int'(last_q) + off) % N_REQ);
      if (bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State register plus all datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
      t_q     <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      t_q     <= t_d;
      q_q     <= q_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_found) state_d = S_GRANT;
      S_GRANT: state_d = bus.req[idx_q] ? S_APPLY : S_IDLE;
      S_APPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    gnt_d  = gnt_q;
    ack_d  = '0;
    idx_d  = idx_q;
    last_d = last_q;
    t_d    = t_q;
    q_d    = q_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          idx_d          = sel_idx;
        end
      end
      S_GRANT: begin
        // A dropped request is an abort: release the grant, keep last_served.
        if (bus.req[idx_q]) t_d = mask_arr[idx_q];
        else                gnt_d = '0;
      end
      S_APPLY: begin
        q_d          = q_q ^ t_q;
        ack_d[idx_q] = 1'b1;
        gnt_d        = '0;
        last_d       = idx_q;
      end
      default: gnt_d = '0;
    endcase
    // Clear wins over a toggle landing on the same edge.
    if (bus.clr) q_d = '0;
  end

  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.q    = q_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// tb/tb_toggle_bank_arbiter.sv - scoreboard bench for toggle_bank_arbiter
module tb_toggle_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toggle_bank_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  toggle_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int           exp_idx_q [$];
  logic [W-1:0] exp_val_q [$];

  logic [W-1:0] m_q;
  int           m_last;
  logic [W-1:0] msk [N];
  logic [N-1:0] mon_prev_gnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_masks();
    for (int i = 0; i < N; i++) bus.mask[i*W +: W] = msk[i];
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] pat);
    for (int off = 1; off <= N; off++) begin
      if (pat[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_q    = '0;
    m_last = N - 1;
    exp_idx_q.delete();
    exp_val_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.clr  = 1'b0;
    for (int i = 0; i < N; i++) msk[i] = '0;
    drive_masks();
    #1;
    check("reset q", 32'(bus.q), 0);
    check("reset gnt", 32'(bus.gnt), 0);
    check("reset ack", 32'(bus.ack), 0);
    check("reset busy", 32'(bus.busy), 0);
    step();
    step();
    rst = 1'b0;
    model_reset();
    #1;
    check("post-reset busy", 32'(bus.busy), 0);
  endtask

  // One transaction starting with the DUT idle at the next edge.
  task automatic do_txn(input logic [N-1:0] pat, input bit clr_apply, input bit abort,
                        input bit rand_others, input string tag);
    int w;
    logic [W-1:0] q_before;
    w = rr_pick(m_last, pat);
    q_before = m_q;
    bus.req = pat;
    drive_masks();
    if (!abort) begin
      m_q    = clr_apply ? '0 : (m_q ^ msk[w]);
      m_last = w;
      exp_idx_q.push_back(w);
      exp_val_q.push_back(m_q);
    end
    step();
    check({tag, " gnt"}, 32'(bus.gnt), 32'(1 << w));
    check({tag, " busy"}, 32'(bus.busy), 1);
    if (abort) begin
      bus.req = '0;
      step();
      check({tag, " abort gnt"}, 32'(bus.gnt), 0);
      check({tag, " abort busy"}, 32'(bus.busy), 0);
      check({tag, " abort q"}, 32'(bus.q), 32'(q_before));
    end else begin
      if (rand_others) begin
        for (int i = 0; i < N; i++) begin
          if (i != w) begin
            bus.req[i] = 1'($urandom_range(0, 1));
            msk[i]     = W'($urandom);
          end
        end
        drive_masks();
      end
      step();
      check({tag, " gnt hold"}, 32'(bus.gnt), 32'(1 << w));
      if (clr_apply) bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      check({tag, " gnt release"}, 32'(bus.gnt), 0);
      bus.req = '0;
    end
  endtask

  // Monitor: per-cycle invariants and scoreboard pop on every ack.
  initial begin
    mon_prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev_gnt = '0;
      end else begin
        check("inv gnt onehot0", 32'($onehot0(bus.gnt)), 1);
        check("inv ack onehot0", 32'($onehot0(bus.ack)), 1);
        check("inv ack vs prev gnt", 32'(bus.ack & ~mon_prev_gnt), 0);
        check("inv busy", 32'(bus.busy), 32'(bus.gnt != '0));
        if (bus.ack != '0) begin
          if (exp_idx_q.size() == 0) begin
            check("unexpected ack", 32'(bus.ack), 0);
          end else begin
            int           ei;
            logic [W-1:0] ev;
            ei = exp_idx_q.pop_front();
            ev = exp_val_q.pop_front();
            check("sb ack", 32'(bus.ack), 32'(1 << ei));
            check("sb q", 32'(bus.q), 32'(ev));
          end
        end
        mon_prev_gnt = bus.gnt;
      end
    end
  end

  initial begin
    logic [W-1:0] rr_q   [5];
    int           rr_ord [5];
    int           w;
    rr_q   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};
    rr_ord = '{0, 1, 2, 3, 0};

    do_reset();

    // Single request, then the same request again toggles back.
    msk[2] = 8'hA5;
    do_txn(4'b0100, 0, 0, 0, "single1");
    check("single1 q", 32'(bus.q), 32'h A5);
    do_txn(4'b0100, 0, 0, 0, "single2");
    check("single2 q", 32'(bus.q), 32'h00);

    // Round robin under continuous requests from all requesters.
    do_reset();
    msk[0] = 8'h01; msk[1] = 8'h02; msk[2] = 8'h04; msk[3] = 8'h08;
    for (int i = 0; i < 5; i++) begin
      do_txn(4'b1111, 0, 0, 0, "rr");
      check("rr ack order", 32'(bus.ack), 32'(1 << rr_ord[i]));
      check("rr q", 32'(bus.q), 32'(rr_q[i]));
    end

    // Abort in the GRANT cycle, then 1 beats 3 with last_served=0.
    msk[1] = 8'h55; msk[3] = 8'hAA;
    do_txn(4'b0010, 0, 1, 0, "abort");
    do_txn(4'b1010, 0, 0, 0, "post-abort");
    check("post-abort q", 32'(bus.q), 32'(8'h0E ^ 8'h55));

    // Zero mask completes with q unchanged.
    for (int i = 0; i < N; i++) msk[i] = '0;
    do_txn(4'b0100, 0, 0, 0, "zero-mask");
    check("zero-mask q", 32'(bus.q), 32'(8'h0E ^ 8'h55));

    // clr collides with APPLY.
    msk[3] = m_q ^ 8'hFF;
    do_txn(4'b1000, 0, 0, 0, "to-ff");
    check("to-ff q", 32'(bus.q), 32'hFF);
    msk[0] = 8'h0F;
    do_txn(4'b0001, 1, 0, 0, "clr-collide");
    check("clr-collide q", 32'(bus.q), 32'h00);
    check("clr-collide ack", 32'(bus.ack), 32'h1);

    // Reset while in APPLY abandons the toggle.
    msk[2] = 8'h3C;
    do_txn(4'b0100, 0, 0, 0, "pre-rst");
    check("pre-rst q", 32'(bus.q), 32'h3C);
    msk[3] = 8'hC3;
    drive_masks();
    w = rr_pick(m_last, 4'b1000);
    bus.req = 4'b1000;
    step();
    check("midrst gnt", 32'(bus.gnt), 32'(1 << w));
    step();
    rst = 1'b1;
    #1;
    check("midrst q", 32'(bus.q), 0);
    check("midrst gnt0", 32'(bus.gnt), 0);
    check("midrst ack", 32'(bus.ack), 0);
    check("midrst busy", 32'(bus.busy), 0);
    step();
    check("midrst ack later", 32'(bus.ack), 0);
    check("midrst q later", 32'(bus.q), 0);
    bus.req = '0;
    rst = 1'b0;
    model_reset();
    do_txn(4'b1000, 0, 0, 0, "post-rst");
    check("post-rst q", 32'(bus.q), 32'hC3);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < N; i++) msk[i] = W'($urandom);
      do_txn(N'($urandom_range(1, (1 << N) - 1)),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 9) == 0),
             1, "rand");
    end

    step();
    step();
    step();
    check("scoreboard drained", 32'(exp_idx_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
